esc_pwm_generator: RTL and testbench
====================================

// Module: esc_pwm_generator
// PURPOSE
//  Consumes the 8-bit total duty value (0..100 = 0%..100%) from the motor offset summer.
//  Produces one glitch-free ESC PWM output per motor, with an arming sequence.
//  The duty value loads only at period boundaries. The block clamps out-of-range duty values.
//  One instance per motor; pwm_out drives the ESC pin.
// PARAMETERS
//  PRESCALE     10000  clk cycles per duty step; period = 100*PRESCALE clk
//  ARM_PERIODS  100    full periods held at IDLE_DUTY before entering RUN (>=1)
//  SLEW_STEP    2      max duty change per period when PWM_SLEW_EN is defined (>=1)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active-high
//  duty_in      in   8  requested duty, 0..100; >100 is clamped
//  arm          in   1  level; 1 = arm/run, 0 = motors off
//  pwm_out      out  1  registered PWM output to the ESC
//  period_start out  1  1-clk pulse on the first clk of each period
//  duty_active  out  8  duty currently in effect
//  armed        out  1  1 while state==RUN
//  clamp_flag   out  1  1-clk pulse: duty_in sampled at a boundary was >100
// BEHAVIOUR
//  Reset values: pwm_out=0, period_start=0, duty_active=0, armed=0, clamp_flag=0.
//    Reset also sets state=DISARMED, pre_cnt=0, step_cnt=0, arm_cnt=0.
//  Timebase:
//   - pre_cnt counts 0..PRESCALE-1. step_cnt advances when pre_cnt wraps and counts 0..99.
//   - Boundary = the clk edge where pre_cnt==PRESCALE-1 and step_cnt==99.
//   - period_start is registered. It is 1 in the clk where both counters are 0,
//     including the first clk after reset release.
//  Output:
//   - pwm_out <= (step_cnt < duty_active), registered, so it lags the counters by 1 clk.
//   - High time per period = duty_active*PRESCALE clk.
//   - duty 0: pwm_out constantly 0. duty 100: pwm_out constantly 1, with no low glitch at the boundary.
//  Target: tgt = (duty_in > 100) ? 100 : duty_in, sampled only at the boundary edge.
//    clamp_flag pulses in the clk after that edge.
//  FSM (transitions at the boundary edge unless noted):
//   - DISARMED: duty_active=0. If arm==1 at the boundary: go to ARMING, arm_cnt=0,
//     duty_active<=IDLE_DUTY.
//   - ARMING: duty_active=IDLE_DUTY. arm_cnt increments each boundary.
//     On the boundary where arm_cnt==ARM_PERIODS-1: go to RUN, duty_active<=tgt.
//   - RUN: duty_active updated from tgt each boundary. armed=1.
//   - arm==0 in ARMING or RUN (any clk, not only at a boundary): go to DISARMED on the
//     next edge, duty_active<=0, arm_cnt<=0, armed<=0. pwm_out is low 1 clk later.
//     This safety path is the only mid-period change of duty_active.
//  Simultaneous events: arm falling on a boundary edge -> DISARMED wins; tgt is discarded.
//  Reset mid-period: everything returns to reset values; no partial pulse completes.
//  Widths: counters sized by $clog2. Duty comparisons are unsigned 8-bit. No wrap beyond 100.
// CONFIGURATION
//  PWM_SLEW_EN defined, in RUN only:
//   - duty_active moves toward tgt by at most SLEW_STEP per boundary. It lands exactly on tgt
//     with no overshoot.
//   - Entry to RUN starts from IDLE_DUTY and slews.
//   - The DISARMED path stays immediate.
//  PWM_SLEW_EN undefined: duty_active<=tgt at each RUN boundary.
// STRUCTURE
//  Package drone_pwm_pkg:
//   - MAX_DUTY=8'd100, IDLE_DUTY=8'h32 (ESC idle level)
//   - state enum {DISARMED, ARMING, RUN}
//   - function clamp_duty
//  Sub-module pwm_timebase(clk, rst, pre_cnt, step_cnt, boundary, period_start) holds both
//    counters. The FSM, slew and compare logic stay in esc_pwm_generator.
// TESTING (bench: PRESCALE=4, ARM_PERIODS=2, SLEW_STEP=2; period=400 clk)
//  - Reset, arm=0, duty_in=60 -> pwm_out=0 for 3 periods. period_start every 400 clk. duty_active=0.
//  - arm=1 -> 2 periods high for 200 clk each (0x32*4), then RUN. armed=1. With duty_in=60: 240 clk high.
//  - In RUN, duty_in 60->20 mid-period -> current period still 240 clk high; next period 80 clk high.
//    Under PWM_SLEW_EN it steps 58,56,... per period down to 20.
//  - duty_in=150 at a boundary -> duty_active=100, clamp_flag 1-clk pulse, pwm_out high across 2 full periods.
//    duty_in=0 -> pwm_out 0 for the whole period.
//  - arm 1->0 at step_cnt=10 with duty=60 -> pwm_out low within 2 clk, state DISARMED.
//    arm falling exactly on a boundary edge -> DISARMED; new tgt is not applied.
//  - rst pulse mid-RUN -> all outputs at reset values next clk. Re-arming repeats the full ARM_PERIODS sequence.

Source files
------------

// File: rtl/drone_pwm_pkg.sv
// Shared definitions for the ESC PWM generator.
//   MAX_DUTY    : highest legal duty value (100 = 100 %)
//   IDLE_DUTY   : duty held while the ESC is being armed
//   STEPS/STEP_W: duty steps per PWM period and the width of the step counter
//   state_t     : arming state machine encoding
//   clamp_duty  : limits a requested duty to MAX_DUTY
//   slew_toward : moves a duty toward a target by at most 'step', never overshooting
package drone_pwm_pkg;

    localparam logic [7:0] MAX_DUTY  = 8'd100;
    localparam logic [7:0] IDLE_DUTY = 8'h32;
    localparam int         STEPS     = 100;
    localparam int         STEP_W    = $clog2(STEPS);

    typedef enum logic [1:0] {
        DISARMED,
        ARMING,
        RUN
    } state_t;

    function automatic logic [7:0] clamp_duty(input logic [7:0] duty);
        return (duty > MAX_DUTY) ? MAX_DUTY : duty;
    endfunction

    // A step of MAX_DUTY or more always lands on the target in one move.
    function automatic logic [7:0] slew_toward(input logic [7:0] cur,
                                               input logic [7:0] tgt,
                                               input logic [7:0] step);
        if (tgt > cur)
            return ((tgt - cur) > step) ? (cur + step) : tgt;
        else
            return ((cur - tgt) > step) ? (cur - step) : tgt;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM period timebase: a prescaler feeding a 0..99 duty-step counter.
// Ports:
//   clk          in  system clock
//   rst          in  synchronous active-high reset
//   pre_cnt      out prescaler count, 0..PRESCALE-1
//   step_cnt     out duty-step count, 0..99
//   boundary     out high during the last clk of a period (the edge ending it loads new duty)
//   period_start out registered, high in the clk where both counters are 0
module pwm_timebase
    import drone_pwm_pkg::*;
#(
    parameter int PRESCALE = 10000,
    parameter int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PRE_W-1:0]  pre_cnt,
    output logic [STEP_W-1:0] step_cnt,
    output logic              boundary,
    output logic              period_start
);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

    logic started;
    logic pre_wrap;

    assign pre_wrap = started && (pre_cnt == PRE_LAST);
    assign boundary = pre_wrap && (step_cnt == STEP_LAST);

    // The counters idle at zero for one clk after reset release so that
    // period_start can be raised for the very first period as well; from
    // then on it is simply the boundary delayed by one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt      <= '0;
            step_cnt     <= '0;
            started      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            started      <= 1'b1;
            period_start <= !started || boundary;
            if (started) begin
                if (pre_wrap) begin
                    pre_cnt  <= '0;
                    step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
                end else begin
                    pre_cnt <= pre_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/esc_pwm_generator.sv
// ESC PWM generator with arming sequence, one instance per motor.
// Optional feature macro: PWM_SLEW_EN (limits duty change in RUN to SLEW_STEP per period).
// Ports:
//   clk          in  system clock
//   rst          in  synchronous active-high reset
//   duty_in      in  requested duty 0..100, larger values are clamped
//   arm          in  level, 1 = arm/run, 0 = motors off
//   pwm_out      out registered PWM output to the ESC pin
//   period_start out 1-clk pulse on the first clk of each period
//   duty_active  out duty currently in effect
//   armed        out high while in RUN
//   clamp_flag   out 1-clk pulse when duty_in sampled at a boundary exceeded 100
module esc_pwm_generator
    import drone_pwm_pkg::*;
#(
    parameter int PRESCALE    = 10000,
    parameter int ARM_PERIODS = 100,
    parameter int SLEW_STEP   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] duty_in,
    input  logic       arm,
    output logic       pwm_out,
    output logic       period_start,
    output logic [7:0] duty_active,
    output logic       armed,
    output logic       clamp_flag
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int ARM_W = (ARM_PERIODS > 1) ? $clog2(ARM_PERIODS) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_PERIODS - 1);

`ifdef PWM_SLEW_EN
    localparam bit SLEW_ON = 1'b1;
`else
    localparam bit SLEW_ON = 1'b0;
`endif

    // Without slewing a full-scale step makes every RUN update immediate.
    localparam logic [7:0] RUN_STEP =
        (SLEW_ON && (SLEW_STEP < 100)) ? 8'(SLEW_STEP) : MAX_DUTY;

    logic [PRE_W-1:0]  pre_cnt_unused;
    logic [STEP_W-1:0] step_cnt;
    logic              boundary;

    state_t            state;
    state_t            state_next;
    logic [7:0]        duty_next;
    logic [ARM_W-1:0]  arm_cnt;
    logic [ARM_W-1:0]  arm_cnt_next;
    logic              clamp_next;
    logic [7:0]        tgt;

    // The prescaler count is only needed inside the timebase.
    pwm_timebase #(
        .PRESCALE (PRESCALE),
        .PRE_W    (PRE_W)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .pre_cnt      (pre_cnt_unused),
        .step_cnt     (step_cnt),
        .boundary     (boundary),
        .period_start (period_start)
    );

    assign tgt = clamp_duty(duty_in);

    // Arming FSM. Duty only changes at a period boundary, except for the
    // disarm path which drops the output as soon as arm goes low and takes
    // priority over a boundary update in the same clk.
    always_comb begin
        state_next   = state;
        duty_next    = duty_active;
        arm_cnt_next = arm_cnt;
        clamp_next   = boundary && (duty_in > MAX_DUTY);

        if ((state != DISARMED) && !arm) begin
            state_next   = DISARMED;
            duty_next    = '0;
            arm_cnt_next = '0;
        end else begin
            case (state)
                DISARMED: begin
                    duty_next = '0;
                    if (boundary && arm) begin
                        state_next   = ARMING;
                        arm_cnt_next = '0;
                        duty_next    = IDLE_DUTY;
                    end
                end
                ARMING: begin
                    duty_next = IDLE_DUTY;
                    if (boundary) begin
                        if (arm_cnt == ARM_LAST) begin
                            state_next = RUN;
                            duty_next  = slew_toward(IDLE_DUTY, tgt, RUN_STEP);
                        end else begin
                            arm_cnt_next = arm_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (boundary)
                        duty_next = slew_toward(duty_active, tgt, RUN_STEP);
                end
                default: begin
                    state_next   = DISARMED;
                    duty_next    = '0;
                    arm_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= DISARMED;
        else
            state <= state_next;
    end

    // pwm_out compares against the duty in effect during the current step,
    // so a duty of 100 stays high straight through the boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_active <= '0;
            arm_cnt     <= '0;
            armed       <= 1'b0;
            clamp_flag  <= 1'b0;
            pwm_out     <= 1'b0;
        end else begin
            duty_active <= duty_next;
            arm_cnt     <= arm_cnt_next;
            armed       <= (state_next == RUN);
            clamp_flag  <= clamp_next;
            pwm_out     <= (8'(step_cnt) < duty_active);
        end
    end

endmodule

// File: tb/tb_esc_pwm_generator.sv
// Self-checking bench for esc_pwm_generator (PRESCALE=4, ARM_PERIODS=2, SLEW_STEP=2).
// A behavioural model predicts each period's high time, clamp pulses and the
// duty/armed state after the boundary; predictions are queued and compared
// when the period has been observed.
module tb_esc_pwm_generator;

    localparam int PRESCALE    = 4;
    localparam int ARM_PERIODS = 2;
    localparam int SLEW_STEP   = 2;
    localparam int PERIOD      = 100 * PRESCALE;
    localparam int M_DIS       = 0;
    localparam int M_ARMING    = 1;
    localparam int M_RUN       = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] duty_in;
    logic       arm;
    logic       pwm_out;
    logic       period_start;
    logic [7:0] duty_active;
    logic       armed;
    logic       clamp_flag;

    typedef struct {
        int         hi;
        int         clamps;
        logic [7:0] duty;
        logic       armed;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    int m_state;
    int m_duty;
    int m_arm_cnt;

    esc_pwm_generator #(
        .PRESCALE    (PRESCALE),
        .ARM_PERIODS (ARM_PERIODS),
        .SLEW_STEP   (SLEW_STEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .duty_in      (duty_in),
        .arm          (arm),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .duty_active  (duty_active),
        .armed        (armed),
        .clamp_flag   (clamp_flag)
    );

    always #5 clk = ~clk;

    // Model of the duty update applied in RUN at a boundary.
    function automatic int m_next_run(input int cur, input int tgt);
`ifdef PWM_SLEW_EN
        if (tgt > cur + SLEW_STEP) return cur + SLEW_STEP;
        if (tgt < cur - SLEW_STEP) return cur - SLEW_STEP;
        return tgt;
`else
        return tgt;
`endif
    endfunction

    task automatic model_reset();
        m_state   = M_DIS;
        m_duty    = 0;
        m_arm_cnt = 0;
    endtask

    task automatic model_boundary(input logic a, input int din);
        int tgt;
        tgt = (din > 100) ? 100 : din;
        if (!a) begin
            model_reset();
        end else begin
            case (m_state)
                M_DIS: begin
                    m_state   = M_ARMING;
                    m_arm_cnt = 0;
                    m_duty    = 50;
                end
                M_ARMING: begin
                    if (m_arm_cnt == ARM_PERIODS - 1) begin
                        m_state = M_RUN;
                        m_duty  = m_next_run(50, tgt);
                    end else begin
                        m_arm_cnt++;
                    end
                end
                default: m_duty = m_next_run(m_duty, tgt);
            endcase
        end
    endtask

    // Queue the prediction for one period given the inputs seen at its boundary.
    task automatic plan_window(input logic arm_b, input int duty_b);
        exp_t e;
        e.hi     = m_duty * PRESCALE;
        e.clamps = (duty_b > 100) ? 1 : 0;
        model_boundary(arm_b, duty_b);
        e.duty   = 8'(m_duty);
        e.armed  = (m_state == M_RUN);
        sbq.push_back(e);
    endtask

    task automatic sync_to_period();
        int n;
        n = 0;
        while (period_start !== 1'b1 && n < 2 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (period_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sync_period_start: actual %b required 1", period_start);
        end
    endtask

    // Starts at the negedge of a period_start clk and observes one full period
    // of pwm_out (which lags the counters by one clk), ending at the negedge
    // of the next period_start clk. Inputs can be changed at sample index mid_at.
    task automatic measure_window(input int mid_at, input logic mid_arm, input logic [7:0] mid_duty,
                                  output int hi, output int clamps, output int pss,
                                  output logic ps_last, output logic [7:0] duty_end,
                                  output logic armed_end);
        hi = 0; clamps = 0; pss = 0;
        if (mid_at == 0) begin
            arm     = mid_arm;
            duty_in = mid_duty;
        end
        for (int i = 1; i <= PERIOD; i++) begin
            @(negedge clk);
            if (pwm_out === 1'b1)      hi++;
            if (clamp_flag === 1'b1)   clamps++;
            if (period_start === 1'b1) pss++;
            if (i == mid_at) begin
                arm     = mid_arm;
                duty_in = mid_duty;
            end
        end
        ps_last   = period_start;
        duty_end  = duty_active;
        armed_end = armed;
    endtask

    task automatic test_reset();
        rst = 1'b1; arm = 1'b0; duty_in = 8'd60;
        repeat (3) @(negedge clk);
        checks++; if (pwm_out !== 1'b0)      begin errors++; $display("[TB] FAIL reset_pwm_out: actual %b required 0", pwm_out); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_period_start: actual %b required 0", period_start); end
        checks++; if (duty_active !== 8'd0)  begin errors++; $display("[TB] FAIL reset_duty_active: actual %0d required 0", duty_active); end
        checks++; if (armed !== 1'b0)        begin errors++; $display("[TB] FAIL reset_armed: actual %b required 0", armed); end
        checks++; if (clamp_flag !== 1'b0)   begin errors++; $display("[TB] FAIL reset_clamp_flag: actual %b required 0", clamp_flag); end
        rst = 1'b0;
        model_reset();
        sync_to_period();
    endtask

    task automatic test_disarmed();
        int hi, cl, pss; logic psl, ae; logic [7:0] de; exp_t e;
        for (int w = 0; w < 3; w++) begin
            plan_window(1'b0, 60);
            measure_window(-1, 1'b0, 8'd60, hi, cl, pss, psl, de, ae);
            e = sbq.pop_front();
            checks++; if (hi !== e.hi)                   begin errors++; $display("[TB] FAIL disarmed_hi[%0d]: actual %0d required %0d", w, hi, e.hi); end
            checks++; if (pss !== 1 || psl !== 1'b1)     begin errors++; $display("[TB] FAIL disarmed_period[%0d]: actual pulses %0d last %b required 1 1", w, pss, psl); end
            checks++; if (de !== e.duty || ae !== e.armed) begin errors++; $display("[TB] FAIL disarmed_state[%0d]: actual %0d/%b required %0d/%b", w, de, ae, e.duty, e.armed); end
        end
    endtask

    task automatic test_arming(input string tag);
        int hi, cl, pss; logic psl, ae; logic [7:0] de; exp_t e;
        for (int w = 0; w < 4; w++) begin
            plan_window(1'b1, 60);
            measure_window((w == 0) ? 0 : -1, 1'b1, 8'd60, hi, cl, pss, psl, de, ae);
            e = sbq.pop_front();
            checks++; if (hi !== e.hi)                   begin errors++; $display("[TB] FAIL %s_hi[%0d]: actual %0d required %0d", tag, w, hi, e.hi); end
            checks++; if (pss !== 1 || psl !== 1'b1)     begin errors++; $display("[TB] FAIL %s_period[%0d]: actual pulses %0d last %b required 1 1", tag, w, pss, psl); end
            checks++; if (de !== e.duty || ae !== e.armed) begin errors++; $display("[TB] FAIL %s_state[%0d]: actual %0d/%b required %0d/%b", tag, w, de, ae, e.duty, e.armed); end
        end
    endtask

    task automatic test_duty_change();
        int hi, cl, pss; logic psl, ae; logic [7:0] de; exp_t e;
        for (int w = 0; w < 3; w++) begin
            plan_window(1'b1, 20);
            measure_window((w == 0) ? 100 : -1, 1'b1, 8'd20, hi, cl, pss, psl, de, ae);
            e = sbq.pop_front();
            checks++; if (hi !== e.hi)       begin errors++; $display("[TB] FAIL change_hi[%0d]: actual %0d required %0d", w, hi, e.hi); end
            checks++; if (de !== e.duty)     begin errors++; $display("[TB] FAIL change_duty[%0d]: actual %0d required %0d", w, de, e.duty); end
        end
    endtask

    task automatic test_clamp();
        int hi, cl, pss; logic psl, ae; logic [7:0] de; exp_t e;
        int seq[4] = '{150, 150, 0, 0};
        for (int w = 0; w < 4; w++) begin
            plan_window(1'b1, seq[w]);
            measure_window((w == 0 || w == 2) ? 0 : -1, 1'b1, 8'(seq[w]), hi, cl, pss, psl, de, ae);
            e = sbq.pop_front();
            checks++; if (hi !== e.hi)       begin errors++; $display("[TB] FAIL clamp_hi[%0d]: actual %0d required %0d", w, hi, e.hi); end
            checks++; if (cl !== e.clamps)   begin errors++; $display("[TB] FAIL clamp_pulses[%0d]: actual %0d required %0d", w, cl, e.clamps); end
            checks++; if (de !== e.duty)     begin errors++; $display("[TB] FAIL clamp_duty[%0d]: actual %0d required %0d", w, de, e.duty); end
        end
    endtask

    task automatic test_disarm_mid();
        int hi, cl, pss; logic psl, ae; logic [7:0] de; exp_t e;
        plan_window(1'b1, 60);
        measure_window(0, 1'b1, 8'd60, hi, cl, pss, psl, de, ae);
        e = sbq.pop_front();
        checks++; if (hi !== e.hi) begin errors++; $display("[TB] FAIL disarm_load_hi: actual %0d required %0d", hi, e.hi); end
        // arm drops at step 10: pwm stays high through at most the 41st sample.
        e.hi     = (m_duty * PRESCALE < 41) ? m_duty * PRESCALE : 41;
        e.clamps = 0;
        model_reset();
        e.duty   = 8'd0;
        e.armed  = 1'b0;
        sbq.push_back(e);
        measure_window(10 * PRESCALE, 1'b0, 8'd60, hi, cl, pss, psl, de, ae);
        e = sbq.pop_front();
        checks++; if (hi !== e.hi)                     begin errors++; $display("[TB] FAIL disarm_mid_hi: actual %0d required %0d", hi, e.hi); end
        checks++; if (de !== e.duty || ae !== e.armed) begin errors++; $display("[TB] FAIL disarm_mid_state: actual %0d/%b required %0d/%b", de, ae, e.duty, e.armed); end
    endtask

    task automatic test_back_to_back();
        int hi, cl, pss; logic psl, ae; logic [7:0] de; exp_t e;
        test_arming("rearm");
        for (int w = 0; w < 2; w++) begin
            plan_window(1'b0, 80);
            measure_window((w == 0) ? PERIOD - 1 : -1, 1'b0, 8'd80, hi, cl, pss, psl, de, ae);
            e = sbq.pop_front();
            checks++; if (hi !== e.hi)                     begin errors++; $display("[TB] FAIL edge_disarm_hi[%0d]: actual %0d required %0d", w, hi, e.hi); end
            checks++; if (de !== e.duty || ae !== e.armed) begin errors++; $display("[TB] FAIL edge_disarm_state[%0d]: actual %0d/%b required %0d/%b", w, de, ae, e.duty, e.armed); end
        end
    endtask

    task automatic test_reset_mid_run();
        logic exp_pwm;
        test_arming("prerst");
        repeat (150) @(negedge clk);
        exp_pwm = (37 < m_duty);
        checks++; if (pwm_out !== exp_pwm) begin errors++; $display("[TB] FAIL midrun_pwm: actual %b required %b", pwm_out, exp_pwm); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (pwm_out !== 1'b0)      begin errors++; $display("[TB] FAIL midrst_pwm_out: actual %b required 0", pwm_out); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("[TB] FAIL midrst_period_start: actual %b required 0", period_start); end
        checks++; if (duty_active !== 8'd0)  begin errors++; $display("[TB] FAIL midrst_duty_active: actual %0d required 0", duty_active); end
        checks++; if (armed !== 1'b0)        begin errors++; $display("[TB] FAIL midrst_armed: actual %b required 0", armed); end
        checks++; if (clamp_flag !== 1'b0)   begin errors++; $display("[TB] FAIL midrst_clamp_flag: actual %b required 0", clamp_flag); end
        rst = 1'b0;
        model_reset();
        sync_to_period();
        test_arming("postrst");
    endtask

    initial begin
        test_reset();
        test_disarmed();
        test_arming("arm");
        test_duty_change();
        test_clamp();
        test_disarm_mid();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
